// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------+
// | uart_pkg: shared UART byte type and FIFO defaults.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package uart_pkg;
  typedef logic [7:0] uart_byte_t;
  localparam int UART_FIFO_DEPTH_DEF = 16;
  localparam uart_byte_t UART_DROP_CNT_MAX = 8'hFF;
endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
// +--------------------------------------------------------------------+
// | uart_rx_fifo_mem: DEPTH x byte storage, sync write / async read.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK_125MHZ_FPGA,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // No reset on the array so it maps onto distributed RAM.
  uart_byte_t r_mem [DEPTH];

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// +--------------------------------------------------------------------+
// | uart_rx_fifo: FWFT byte FIFO behind the uart_core rx port.         |
// | Optional statistics (drop_cnt, max_level): UART_RX_FIFO_STATS_EN.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        CLK_125MHZ_FPGA,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [AW:0] level,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic [AW:0] max_level
);

  localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_level;
  logic        r_overflow;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // in_ready depends only on registered pointers; a pop never frees a slot in the same cycle.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && !w_full && !rst;
  assign w_pop     = !w_empty && out_ready && !rst;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK_125MHZ_FPGA (CLK_125MHZ_FPGA),
    .we              (w_push),
    .waddr           (r_wr_ptr[AW-1:0]),
    .wdata           (in_data),
    .raddr           (r_rd_ptr[AW-1:0]),
    .rdata           (out_data)
  );

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_ptr_one;
        2'b01:   r_level <= r_level - c_ptr_one;
        default: r_level <= r_level;
      endcase
      if (in_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign level    = r_level;
  assign overflow = r_overflow;

`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0]  r_drop_cnt;
  logic [AW:0] r_max_level;

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (rst) begin
      r_drop_cnt  <= '0;
      r_max_level <= '0;
    end else begin
      if (in_valid && w_full && (r_drop_cnt != UART_DROP_CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (r_level > r_max_level) begin
        r_max_level <= r_level;
      end
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign max_level = r_max_level;
`else
  assign drop_cnt  = '0;
  assign max_level = '0;
`endif

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte FIFO between the uart_core rx side (data_out/data_out_valid/data_out_ready) and the FPGA consumer logic (loopback / case-swap, future command parser).
- Absorbs bursts while the tx path is busy. Flags bytes lost on overflow.
- Ready/valid on both sides. First-word-fall-through output.

Parameters:
- DEPTH, 16, number of byte entries; power of 2, >= 2.
- AW, $clog2(DEPTH), derived pointer width; do not override.

Ports:
- CLK_125MHZ_FPGA  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  8  byte from uart_core data_out
- in_valid  input  1  from uart_core data_out_valid
- in_ready  output  1  to uart_core data_out_ready
- out_data  output  8  head byte
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts head byte
- level  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: in_valid seen while full
- drop_cnt  output  8  bytes dropped (feature-gated)
- max_level  output  AW+1  high-water mark (feature-gated)

Behaviour:
- Storage: DEPTH x 8 array. wr_ptr/rd_ptr are AW+1 bits, with the extra MSB acting as a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, overflow=0, drop_cnt=0, max_level=0. Hence out_valid=0 and in_ready=1. Array contents are not reset.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = !full, registered-state only. No combinational path from out_ready to in_ready. When full, a simultaneous pop does NOT allow a same-cycle push.
- out_valid = !empty. out_data = mem[rd_ptr[AW-1:0]], combinational read (FWFT).
- Latency:
  - Byte pushed in cycle N appears on out_data/out_valid in cycle N+1 when the FIFO was empty.
  - Zero-bubble streaming at one byte per cycle.
- Push: mem[wr_ptr] <= in_data; wr_ptr increments, wrapping naturally modulo 2*DEPTH.
- Pop: rd_ptr increments.
- level: registered.
  - +1 on push only; -1 on pop only; unchanged on push && pop or on neither.
  - Must always equal wr_ptr - rd_ptr (AW+1-bit subtraction).
- Simultaneous push and pop at level 1: both occur and level stays 1. The new byte becomes head the next cycle.
- overflow:
  - Set on any cycle with in_valid && full.
  - Cleared only by rst.
  - The offered byte is not stored, and pointers are unchanged.
- Output hold: out_data must hold stable while out_valid && !out_ready.
- Reset mid-operation: all contents are discarded.
  - out_valid deasserts the cycle after rst is sampled high.
  - No push or pop occurs in a cycle where rst=1.

Optional Feature:
- Macro: UART_RX_FIFO_STATS_EN.
- Defined:
  - drop_cnt increments on each in_valid && full cycle, saturating at 255.
  - max_level <= max(max_level, level) every cycle.
  - Both clear on rst.
- Undefined: drop_cnt and max_level are tied to 0, and no counter logic is synthesised. The port list is identical either way.

Decomposition:
- uart_pkg holds:
  - typedef logic [7:0] uart_byte_t;
  - localparam UART_FIFO_DEPTH_DEF = 16;
  - localparam UART_DROP_CNT_MAX = 8'hFF.
- One sub-module, uart_rx_fifo_mem:
  - DEPTH x uart_byte_t array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata), mapped to distributed RAM.
  - Pointer, level and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, level=0, overflow=0 for 10 cycles.
- Single byte: push 0x41 at cycle N → out_valid=1 with out_data=0x41 at N+1; pop with out_ready=1 → level=0, out_valid=0 next cycle.
- Fill and overflow (DEPTH=16): push 0x00..0x0F with out_ready=0 → level=16, in_ready=0. Offer 0x10 for 3 cycles → overflow=1 and level stays 16; with STATS_EN, drop_cnt=3. Drain → reads 0x00..0x0F in order, and 0x10 is never seen.
- Streaming: continuous push and pop of 0x00..0xFF with out_ready=1 → every byte is received in order, level ≤ 1, and pointers wrap 16 times with no loss.
- Backpressure hold: level=4 and out_ready=0 for 5 cycles → out_data is stable at the head byte; then push and pop together for 8 cycles → level stays 4, and order is preserved.
- Reset mid-burst: level=7 and rst=1 for 1 cycle → next cycle level=0, out_valid=0, overflow=0; with STATS_EN, max_level=0.
